// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: one-hot stage strobes,
// Y86 status tracking and saturating retire/cycle counters.
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             cc_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             wb_en,
  output logic             pc_we,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        icode_r;
  logic [2:0]        stat_r, stat_s;
  logic [WAIT_W-1:0] wait_r, wait_s;
  logic [CNT_W-1:0]  instr_cnt_r, cycle_cnt_r;

  // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
  function automatic logic is_mem_op(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
  endfunction

  function automatic logic writes_reg(input logic [3:0] ic);
    return (ic == 4'h2) || (ic == 4'h3) || (ic == 4'h5) || (ic == 4'h6) ||
           (ic == 4'h8) || (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  // State, status, latched icode, memory wait counter and debug counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      icode_r     <= 4'h0;
      stat_r      <= STAT_AOK;
      wait_r      <= '0;
      instr_cnt_r <= '0;
      cycle_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      stat_r  <= stat_s;
      wait_r  <= wait_s;
      if (state_r == S_FETCH) icode_r <= icode;
      if (state_r == S_PCUPD && instr_cnt_r != '1) instr_cnt_r <= instr_cnt_r + CNT_ONE;
      if (state_r != S_IDLE && state_r != S_HALT && cycle_cnt_r != '1)
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
    end
  end

  // Next-state, status and wait-counter logic
  always_comb begin
    state_s = state_r;
    stat_s  = stat_r;
    wait_s  = wait_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        if (imem_error) begin
          stat_s  = STAT_ADR;
          state_s = S_HALT;
        end else if (!instr_valid) begin
          stat_s  = STAT_INS;
          state_s = S_HALT;
        end else if (icode == 4'h0) begin
          stat_s  = STAT_HLT;
          state_s = S_HALT;
        end else if (icode == 4'h1) begin
          state_s = S_PCUPD;
        end else begin
          state_s = S_DECODE;
        end
      end
      S_DECODE: state_s = S_EXEC;
      S_EXEC: begin
        wait_s = '0;
        if (is_mem_op(icode_r)) state_s = S_MEM;
        else                    state_s = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (dmem_error) begin
            stat_s  = STAT_ADR;
            state_s = S_HALT;
          end else begin
            state_s = S_WB;
          end
        end else if (wait_r == WAIT_LAST) begin
          stat_s  = STAT_ADR;
          state_s = S_HALT;
        end else begin
          wait_s = wait_r + WAIT_ONE;
        end
      end
      S_WB:    state_s = S_PCUPD;
      S_PCUPD: state_s = S_FETCH;
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // Moore output decode from registered state and latched icode
  always_comb begin
    if_en    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    cc_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wb_en    = 1'b0;
    pc_we    = 1'b0;
    case (state_r)
      S_FETCH:  if_en = 1'b1;
      S_DECODE: id_en = 1'b1;
      S_EXEC: begin
        ex_en = 1'b1;
        cc_we = (icode_r == 4'h6);
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_mem_write(icode_r);
      end
      S_WB:    wb_en = writes_reg(icode_r);
      S_PCUPD: pc_we = 1'b1;
      default: if_en = 1'b0;
    endcase
  end

  assign busy      = (state_r != S_IDLE) && (state_r != S_HALT);
  assign stat      = stat_r;
  assign instr_cnt = instr_cnt_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: a per-cycle vector table for a mixed program,
// plus hand-written sequences for faults, timeouts, mid-instruction reset and saturation.
module tb_seq_stage_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, start, instr_valid, imem_error, dmem_ack, dmem_error;
  logic [3:0] icode;
  logic if_en, id_en, ex_en, cc_we, dmem_req, dmem_we, wb_en, pc_we, busy;
  logic [2:0] stat;
  logic [CNT_W-1:0] instr_cnt, cycle_cnt;

  int errors = 0;
  int checks = 0;

  seq_stage_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .cc_we(cc_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .wb_en(wb_en), .pc_we(pc_we), .stat(stat), .busy(busy),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  typedef struct {
    logic       start;
    logic [3:0] icode;
    logic       ack;
    logic [8:0] exp_s;     // {if,id,ex,cc,req,we,wb,pc,busy}
    logic [2:0] exp_stat;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] prog[$];
  int pc_cnt, wb_cnt, req_cnt, we_cnt, cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [3:0] ic, input logic ack,
                     input logic [8:0] es, input logic [2:0] est);
    vec_t v;
    v.start = st; v.icode = ic; v.ack = ack; v.exp_s = es; v.exp_stat = est;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] strobes();
    return {if_en, id_en, ex_en, cc_we, dmem_req, dmem_we, wb_en, pc_we, busy};
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; icode = 4'h1; instr_valid = 1'b1;
    imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs prog from IDLE; ack_at = index of MEM cycle that acks (-1: never)
  task automatic run_prog(input int ack_at, input logic derr_in, input logic valid_in,
                          input logic ierr_in, input int budget);
    int k = 0;
    int mcyc = 0;
    pc_cnt = 0; wb_cnt = 0; req_cnt = 0; we_cnt = 0; cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < budget && busy; c++) begin
      if (if_en) begin
        icode = (k < prog.size()) ? prog[k] : 4'h0;
        k++;
      end
      instr_valid = valid_in;
      imem_error  = ierr_in;
      dmem_ack    = dmem_req && (mcyc == ack_at);
      dmem_error  = dmem_ack && derr_in;
      mcyc = dmem_req ? mcyc + 1 : 0;
      pc_cnt  += int'(pc_we);
      wb_cnt  += int'(wb_en);
      req_cnt += int'(dmem_req);
      we_cnt  += int'(dmem_we);
      cyc++;
      step();
    end
    dmem_ack = 1'b0; dmem_error = 1'b0; instr_valid = 1'b1; imem_error = 1'b0;
    check("run_terminated", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // OPq, nop, jXX, call (immediate ack), mrmovq (ack on 3rd MEM cycle), halt
    add(1'b1, 4'h0, 1'b0, 9'b000000000, 3'd1);
    add(1'b0, 4'h6, 1'b0, 9'b100000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b010000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b001100001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000101, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000011, 3'd1);
    add(1'b0, 4'h1, 1'b0, 9'b100000001, 3'd1);
    add(1'b1, 4'h0, 1'b0, 9'b000000011, 3'd1);
    add(1'b0, 4'h7, 1'b0, 9'b100000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b010000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b001000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000011, 3'd1);
    add(1'b0, 4'h8, 1'b0, 9'b100000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b010000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b001000001, 3'd1);
    add(1'b0, 4'h0, 1'b1, 9'b000011001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000101, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000011, 3'd1);
    add(1'b0, 4'h5, 1'b0, 9'b100000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b010000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b001000001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000010001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000010001, 3'd1);
    add(1'b0, 4'h0, 1'b1, 9'b000010001, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000101, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b000000011, 3'd1);
    add(1'b0, 4'h0, 1'b0, 9'b100000001, 3'd1);
    add(1'b1, 4'h0, 1'b0, 9'b000000000, 3'd2);
    add(1'b1, 4'h0, 1'b0, 9'b000000000, 3'd2);

    do_reset();
    check("reset_strobes", {23'd0, strobes()}, 32'd0);
    check("reset_stat", {29'd0, stat}, 32'd1);
    check("reset_instr_cnt", {28'd0, instr_cnt}, 32'd0);
    check("reset_cycle_cnt", {28'd0, cycle_cnt}, 32'd0);

    foreach (vecs[i]) begin
      start = vecs[i].start;
      icode = vecs[i].icode;
      dmem_ack = vecs[i].ack;
      check($sformatf("vec%0d_strobes", i), {23'd0, strobes()}, {23'd0, vecs[i].exp_s});
      check($sformatf("vec%0d_stat", i), {29'd0, stat}, {29'd0, vecs[i].exp_stat});
      step();
    end
    start = 1'b0; dmem_ack = 1'b0;
    check("table_instr_cnt", {28'd0, instr_cnt}, 32'd5);
    check("table_cycle_cnt_sat", {28'd0, cycle_cnt}, 32'd15);

    // nop, nop, halt
    do_reset();
    prog = '{4'h1, 4'h1, 4'h0};
    run_prog(-1, 1'b0, 1'b1, 1'b0, 50);
    check("nnh_pc_we", pc_cnt, 32'd2);
    check("nnh_instr_cnt", {28'd0, instr_cnt}, 32'd2);
    check("nnh_stat", {29'd0, stat}, 32'd2);
    check("nnh_cycle_cnt", {28'd0, cycle_cnt}, 32'd5);

    // mrmovq with ack on the third MEM cycle, then halt
    do_reset();
    prog = '{4'h5, 4'h0};
    run_prog(2, 1'b0, 1'b1, 1'b0, 50);
    check("mrm_req_cycles", req_cnt, 32'd3);
    check("mrm_we_cycles", we_cnt, 32'd0);
    check("mrm_wb", wb_cnt, 32'd1);
    check("mrm_pc", pc_cnt, 32'd1);
    check("mrm_cycle_cnt", {28'd0, cycle_cnt}, 32'd9);
    check("mrm_stat", {29'd0, stat}, 32'd2);

    // rmmovq with data fault on ack; later start must be ignored
    do_reset();
    prog = '{4'h4};
    run_prog(0, 1'b1, 1'b1, 1'b0, 50);
    check("rmm_err_stat", {29'd0, stat}, 32'd3);
    check("rmm_err_wb", wb_cnt, 32'd0);
    check("rmm_err_pc", pc_cnt, 32'd0);
    check("rmm_err_we", we_cnt, 32'd1);
    check("rmm_err_cycles", cyc, 32'd4);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("halt_start_ignored_busy", {31'd0, busy}, 32'd0);
    check("halt_start_ignored_if", {31'd0, if_en}, 32'd0);
    check("halt_stat_held", {29'd0, stat}, 32'd3);

    // popq with no ack: timeout after 15 MEM cycles
    do_reset();
    prog = '{4'hB};
    run_prog(-1, 1'b0, 1'b1, 1'b0, 100);
    check("timeout_req_cycles", req_cnt, 32'd15);
    check("timeout_stat", {29'd0, stat}, 32'd3);
    check("timeout_pc", pc_cnt, 32'd0);
    check("timeout_cycle_cnt_sat", {28'd0, cycle_cnt}, 32'd15);

    // illegal instruction, and imem_error taking priority over it
    do_reset();
    prog = '{4'h6};
    run_prog(-1, 1'b0, 1'b0, 1'b0, 20);
    check("ins_stat", {29'd0, stat}, 32'd4);
    check("ins_cycles", cyc, 32'd1);
    do_reset();
    run_prog(-1, 1'b0, 1'b0, 1'b1, 20);
    check("imem_err_stat", {29'd0, stat}, 32'd3);

    // asynchronous reset while waiting in MEM
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    icode = 4'h5;
    repeat (3) step();
    check("pre_rst_in_mem", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_strobes", {23'd0, strobes()}, 32'd0);
    check("async_rst_stat", {29'd0, stat}, 32'd1);
    check("async_rst_cycle_cnt", {28'd0, cycle_cnt}, 32'd0);
    step();
    rst = 1'b0;
    dmem_ack = 1'b1;
    wb_cnt = 0; pc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      wb_cnt += int'(wb_en);
      pc_cnt += int'(pc_we | busy);
      step();
    end
    dmem_ack = 1'b0;
    check("post_rst_no_wb", wb_cnt, 32'd0);
    check("post_rst_idle", pc_cnt, 32'd0);
    check("post_rst_instr_cnt", {28'd0, instr_cnt}, 32'd0);

    // 20 nops: instr_cnt saturates at 15
    do_reset();
    prog.delete();
    for (int i = 0; i < 20; i++) prog.push_back(4'h1);
    prog.push_back(4'h0);
    run_prog(-1, 1'b0, 1'b1, 1'b0, 200);
    check("sat_pc_we", pc_cnt, 32'd20);
    check("sat_instr_cnt", {28'd0, instr_cnt}, 32'd15);
    check("sat_cycle_cnt", {28'd0, cycle_cnt}, 32'd15);
    check("sat_stat", {29'd0, stat}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
